// File: rtl/beacon_cfg_update.sv
// beacon_cfg_update
// Sits in the 134-bit beacon report path in front of the ESW. Update frames addressed to this
// node are absorbed and written atomically into one of NUM_SETS configuration sets. Looped-back
// local frames are dropped, and every other frame is forwarded with a fixed 3-cycle latency.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_lu_data[133:0]          packet word, [133:132] = 01 head / 11 middle / 10 tail
//   in_lu_data_wr              word strobe
//   in_lu_data_valid(_wr)      frame-valid flag and its strobe
//   in_local_mac_id[47:0]      this node's MAC address
//   out_lu_*                   forwarded stream (zero unless forwarding)
//   time_slot_period           32 bits per set, set s at [32s+31:32s]
//   direction                  1 bit per set
//   token_bucket_para/depth    16 bits per set
//   direct_mac_addr            48 bits per set
//   update_toggle              bit s inverts on every commit to set s
//   update_cnt/drop_cnt/err_cnt saturating 16-bit event counters
module beacon_cfg_update #(
  parameter int unsigned NUM_SETS        = 4,
  parameter logic [3:0]  MSG_TYPE_UPDATE = 4'hF,
  parameter int unsigned PAYLOAD_WORD    = 5,
  parameter logic [31:0] RST_PERIOD      = 32'h7,
  parameter logic [15:0] RST_PARA        = 16'd10,
  parameter logic [15:0] RST_DEPTH       = 16'd2048
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [133:0]             in_lu_data,
  input  logic                     in_lu_data_wr,
  input  logic                     in_lu_data_valid,
  input  logic                     in_lu_data_valid_wr,
  input  logic [47:0]              in_local_mac_id,
  output logic [133:0]             out_lu_data,
  output logic                     out_lu_data_wr,
  output logic                     out_lu_data_valid,
  output logic                     out_lu_data_valid_wr,
  output logic [32*NUM_SETS-1:0]   time_slot_period,
  output logic [NUM_SETS-1:0]      direction,
  output logic [16*NUM_SETS-1:0]   token_bucket_para,
  output logic [16*NUM_SETS-1:0]   token_bucket_depth,
  output logic [48*NUM_SETS-1:0]   direct_mac_addr,
  output logic [NUM_SETS-1:0]      update_toggle,
  output logic [15:0]              update_cnt,
  output logic [15:0]              drop_cnt,
  output logic [15:0]              err_cnt
);

  localparam int unsigned SetW       = $clog2(NUM_SETS > 1 ? NUM_SETS : 2);
  localparam logic [4:0]  PayloadIdx = 5'(PAYLOAD_WORD);
  localparam logic [4:0]  NumSetsW   = 5'(NUM_SETS);

  typedef enum logic [1:0] {StIdle, StTran, StUpd, StDisc} state_e;

  function automatic logic [15:0] sat_add(input logic [15:0] v, input logic [1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, v} + {15'd0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  // Two-stage delay line, intentionally without reset.
  logic [133:0] s1_data_q, s2_data_q;
  logic         s1_wr_q, s1_valid_q, s1_vwr_q;
  logic         s2_wr_q, s2_valid_q, s2_vwr_q;

  always_ff @(posedge clk) begin
    s1_data_q  <= in_lu_data;
    s1_wr_q    <= in_lu_data_wr;
    s1_valid_q <= in_lu_data_valid;
    s1_vwr_q   <= in_lu_data_valid_wr;
    s2_data_q  <= s1_data_q;
    s2_wr_q    <= s1_wr_q;
    s2_valid_q <= s1_valid_q;
    s2_vwr_q   <= s1_vwr_q;
  end

  // Classification: s2 holds the head, s1 holds word 1 (frames are contiguous).
  logic        head, tail;
  logic [47:0] f_dst, f_src;
  logic [3:0]  f_type, f_idx;
  logic        is_upd, idx_ok, looped;

  assign head   = s2_wr_q && (s2_data_q[133:132] == 2'b01);
  assign tail   = s2_wr_q && (s2_data_q[133:132] == 2'b10);
  assign f_dst  = s1_data_q[127:80];
  assign f_src  = s1_data_q[79:32];
  assign f_type = s1_data_q[11:8];
  // Range check uses the full low nibble so out-of-range indices are not aliased by truncation.
  assign f_idx  = s1_data_q[3:0];
  assign is_upd = (f_dst == in_local_mac_id) && (f_type == MSG_TYPE_UPDATE);
  assign idx_ok = {1'b0, f_idx} < NumSetsW;
  assign looped = (f_src == in_local_mac_id) && !s2_data_q[127];

  state_e          state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [SetW-1:0] set_q, set_d;

  logic [47:0] sh_mac_q, sh_mac_d;
  logic        sh_dir_q, sh_dir_d;
  logic [15:0] sh_depth_q, sh_depth_d;
  logic [15:0] sh_para_q, sh_para_d;
  logic [31:0] sh_period_q, sh_period_d;

  logic       fwd, commit, upd_inc, drop_inc;
  logic [1:0] err_inc;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    set_d       = set_q;
    sh_mac_d    = sh_mac_q;
    sh_dir_d    = sh_dir_q;
    sh_depth_d  = sh_depth_q;
    sh_para_d   = sh_para_q;
    sh_period_d = sh_period_q;
    fwd         = 1'b0;
    commit      = 1'b0;
    upd_inc     = 1'b0;
    drop_inc    = 1'b0;
    err_inc     = 2'd0;

    if (head) begin
      // A head always starts a new frame; an open TRAN/UPD frame is abandoned as an error.
      if (state_q == StTran || state_q == StUpd) err_inc = err_inc + 2'd1;
      if (is_upd && idx_ok) begin
        state_d = StUpd;
        set_d   = f_idx[SetW-1:0];
        cnt_d   = 5'd1;
      end else if (is_upd) begin
        state_d = StDisc;
        err_inc = err_inc + 2'd1;
      end else if (looped) begin
        state_d  = StDisc;
        drop_inc = 1'b1;
      end else begin
        state_d = StTran;
        fwd     = 1'b1;
      end
    end else begin
      case (state_q)
        StTran: begin
          fwd = 1'b1;
          if (tail) state_d = StIdle;
        end
        StUpd: begin
          if (s2_wr_q) begin
            if (cnt_q == PayloadIdx) begin
              sh_mac_d    = s2_data_q[127:80];
              sh_dir_d    = s2_data_q[79];
              sh_depth_d  = s2_data_q[63:48];
              sh_para_d   = s2_data_q[47:32];
              sh_period_d = s2_data_q[31:0];
            end
            // Saturate so overlong frames cannot wrap and reload the shadow.
            if (cnt_q != 5'd31) cnt_d = cnt_q + 5'd1;
            if (tail) begin
              state_d = StIdle;
              if (cnt_q >= PayloadIdx) begin
                commit  = 1'b1;
                upd_inc = 1'b1;
              end else begin
                err_inc = 2'd1;
              end
            end
          end
        end
        StDisc: begin
          if (tail) state_d = StIdle;
        end
        default: ;
      endcase
    end
  end

  // Commit source: the payload word may itself be the tail, so bypass the shadow in that case.
  logic        byp;
  logic [47:0] com_mac;
  logic        com_dir;
  logic [15:0] com_depth, com_para;
  logic [31:0] com_period;

  assign byp        = (cnt_q == PayloadIdx);
  assign com_mac    = byp ? s2_data_q[127:80] : sh_mac_q;
  assign com_dir    = byp ? s2_data_q[79]     : sh_dir_q;
  assign com_depth  = byp ? s2_data_q[63:48]  : sh_depth_q;
  assign com_para   = byp ? s2_data_q[47:32]  : sh_para_q;
  assign com_period = byp ? s2_data_q[31:0]   : sh_period_q;

  logic [31:0] period_q [NUM_SETS];
  logic [15:0] para_q   [NUM_SETS];
  logic [15:0] depth_q  [NUM_SETS];
  logic [47:0] mac_q    [NUM_SETS];
  logic [NUM_SETS-1:0] dir_q, toggle_q;
  logic [15:0] update_cnt_q, drop_cnt_q, err_cnt_q;
  logic [133:0] out_data_q;
  logic         out_wr_q, out_valid_q, out_vwr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= 5'd0;
      set_q        <= '0;
      sh_mac_q     <= '0;
      sh_dir_q     <= 1'b0;
      sh_depth_q   <= '0;
      sh_para_q    <= '0;
      sh_period_q  <= '0;
      dir_q        <= '0;
      toggle_q     <= '0;
      update_cnt_q <= '0;
      drop_cnt_q   <= '0;
      err_cnt_q    <= '0;
      out_data_q   <= '0;
      out_wr_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_vwr_q    <= 1'b0;
      for (int s = 0; s < NUM_SETS; s++) begin
        period_q[s] <= RST_PERIOD;
        para_q[s]   <= RST_PARA;
        depth_q[s]  <= RST_DEPTH;
        mac_q[s]    <= '0;
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      set_q        <= set_d;
      sh_mac_q     <= sh_mac_d;
      sh_dir_q     <= sh_dir_d;
      sh_depth_q   <= sh_depth_d;
      sh_para_q    <= sh_para_d;
      sh_period_q  <= sh_period_d;
      update_cnt_q <= sat_add(update_cnt_q, {1'b0, upd_inc});
      drop_cnt_q   <= sat_add(drop_cnt_q, {1'b0, drop_inc});
      err_cnt_q    <= sat_add(err_cnt_q, err_inc);
      out_data_q   <= fwd ? s2_data_q  : '0;
      out_wr_q     <= fwd ? s2_wr_q    : 1'b0;
      out_valid_q  <= fwd ? s2_valid_q : 1'b0;
      out_vwr_q    <= fwd ? s2_vwr_q   : 1'b0;
      for (int s = 0; s < NUM_SETS; s++) begin
        if (commit && (set_q == SetW'(s))) begin
          period_q[s] <= com_period;
          para_q[s]   <= com_para;
          depth_q[s]  <= com_depth;
          mac_q[s]    <= com_mac;
          dir_q[s]    <= com_dir;
          toggle_q[s] <= ~toggle_q[s];
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_SETS; g++) begin : g_pack
    assign time_slot_period[32*g +: 32]   = period_q[g];
    assign token_bucket_para[16*g +: 16]  = para_q[g];
    assign token_bucket_depth[16*g +: 16] = depth_q[g];
    assign direct_mac_addr[48*g +: 48]    = mac_q[g];
  end

  assign direction            = dir_q;
  assign update_toggle        = toggle_q;
  assign update_cnt           = update_cnt_q;
  assign drop_cnt             = drop_cnt_q;
  assign err_cnt              = err_cnt_q;
  assign out_lu_data          = out_data_q;
  assign out_lu_data_wr       = out_wr_q;
  assign out_lu_data_valid    = out_valid_q;
  assign out_lu_data_valid_wr = out_vwr_q;

endmodule

// File: tb/tb_beacon_cfg_update.sv
// Directed bench for beacon_cfg_update: forwarding, commit, truncation, bad index, loop drop,
// framing error and mid-frame reset. Inputs change and outputs are sampled on the falling edge.
module tb_beacon_cfg_update;

  localparam int unsigned NumSets     = 4;
  localparam int          PayloadWord = 5;
  localparam logic [47:0] LocalMac    = 48'h0011_2233_4455;
  localparam logic [47:0] ForeignDst  = 48'hAABB_CCDD_EEFF;
  localparam logic [47:0] OtherSrc    = 48'h1234_5678_9ABC;
  localparam logic [127:0] HeadHi     = {1'b1, 123'd0, 4'h1};
  localparam logic [127:0] HeadLo     = 128'h1;
  // mac 0x0A0B0C0D0E0F, dir 1, depth 0x0400, para 0x0020, period 0x1F
  localparam logic [127:0] Payload    = {48'h0A0B_0C0D_0E0F, 1'b1, 15'd0, 16'h0400, 16'h0020,
                                         32'h0000_001F};
  localparam logic [127:0] Payload2   = {48'hDEAD_BEEF_0001, 1'b1, 15'd0, 16'h0111, 16'h0222,
                                         32'h0000_0333};

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [133:0]           in_lu_data;
  logic                   in_lu_data_wr, in_lu_data_valid, in_lu_data_valid_wr;
  logic [133:0]           out_lu_data;
  logic                   out_lu_data_wr, out_lu_data_valid, out_lu_data_valid_wr;
  logic [32*NumSets-1:0]  time_slot_period;
  logic [NumSets-1:0]     direction;
  logic [16*NumSets-1:0]  token_bucket_para;
  logic [16*NumSets-1:0]  token_bucket_depth;
  logic [48*NumSets-1:0]  direct_mac_addr;
  logic [NumSets-1:0]     update_toggle;
  logic [15:0]            update_cnt, drop_cnt, err_cnt;

  always #5 clk = ~clk;

  beacon_cfg_update #(
    .NUM_SETS       (NumSets),
    .MSG_TYPE_UPDATE(4'hF),
    .PAYLOAD_WORD   (PayloadWord),
    .RST_PERIOD     (32'h7),
    .RST_PARA       (16'd10),
    .RST_DEPTH      (16'd2048)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .in_lu_data          (in_lu_data),
    .in_lu_data_wr       (in_lu_data_wr),
    .in_lu_data_valid    (in_lu_data_valid),
    .in_lu_data_valid_wr (in_lu_data_valid_wr),
    .in_local_mac_id     (LocalMac),
    .out_lu_data         (out_lu_data),
    .out_lu_data_wr      (out_lu_data_wr),
    .out_lu_data_valid   (out_lu_data_valid),
    .out_lu_data_valid_wr(out_lu_data_valid_wr),
    .time_slot_period    (time_slot_period),
    .direction           (direction),
    .token_bucket_para   (token_bucket_para),
    .token_bucket_depth  (token_bucket_depth),
    .direct_mac_addr     (direct_mac_addr),
    .update_toggle       (update_toggle),
    .update_cnt          (update_cnt),
    .drop_cnt            (drop_cnt),
    .err_cnt             (err_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Expected output stream: entry k is what the word driven k+1 cycles ago should produce.
  logic [136:0] hist [3];

  function automatic logic [136:0] out_bus();
    return {out_lu_data, out_lu_data_wr, out_lu_data_valid, out_lu_data_valid_wr};
  endfunction

  task automatic cycle(input logic [133:0] d, input logic wr, input logic v, input logic vwr,
                       input bit fwd);
    @(negedge clk);
    check("fwd_stream", 256'(out_bus()), 256'(hist[2]));
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = fwd ? {d, wr, v, vwr} : '0;
    in_lu_data          = d;
    in_lu_data_wr       = wr;
    in_lu_data_valid    = v;
    in_lu_data_valid_wr = vwr;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle('0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [133:0] mk_word(input int i, input int n, input logic [127:0] head,
                                           input logic [47:0] dst, input logic [47:0] src,
                                           input logic [3:0] typ, input logic [3:0] idx,
                                           input logic [127:0] payload);
    logic [1:0]   tag;
    logic [127:0] body;
    tag = (i == 0) ? 2'b01 : ((i == n - 1) ? 2'b10 : 2'b11);
    if (i == 0)                body = head;
    else if (i == 1)           body = {dst, src, 20'd0, typ, 4'd0, idx};
    else if (i == PayloadWord) body = payload;
    else                       body = {96'd0, 16'hC0DE, 16'(i)};
    return {tag, 4'd0, body};
  endfunction

  // Drive words first..last-1 of an n-word frame; valid/valid_wr accompany the tail.
  task automatic send(input int n, input int first, input int last, input logic [127:0] head,
                      input logic [47:0] dst, input logic [47:0] src, input logic [3:0] typ,
                      input logic [3:0] idx, input logic [127:0] payload, input bit fwd);
    for (int i = first; i < last; i++) begin
      cycle(mk_word(i, n, head, dst, src, typ, idx, payload), 1'b1, i == n - 1, i == n - 1, fwd);
    end
  endtask

  task automatic check_set(input int s, input logic [31:0] period, input logic [15:0] para,
                           input logic [15:0] depth, input logic [47:0] mac, input logic dir);
    check($sformatf("set%0d_period", s), 256'(time_slot_period[32*s +: 32]), 256'(period));
    check($sformatf("set%0d_para", s),   256'(token_bucket_para[16*s +: 16]), 256'(para));
    check($sformatf("set%0d_depth", s),  256'(token_bucket_depth[16*s +: 16]), 256'(depth));
    check($sformatf("set%0d_mac", s),    256'(direct_mac_addr[48*s +: 48]), 256'(mac));
    check($sformatf("set%0d_dir", s),    256'(direction[s]), 256'(dir));
  endtask

  task automatic check_set_rst(input int s);
    check_set(s, 32'h7, 16'd10, 16'd2048, 48'h0, 1'b0);
  endtask

  task automatic check_cnts(input string tag, input logic [15:0] upd, input logic [15:0] drop,
                            input logic [15:0] err);
    check({tag, "_update_cnt"}, 256'(update_cnt), 256'(upd));
    check({tag, "_drop_cnt"},   256'(drop_cnt), 256'(drop));
    check({tag, "_err_cnt"},    256'(err_cnt), 256'(err));
  endtask

  task automatic check_all_reset(input string tag);
    check({tag, "_out"}, 256'(out_bus()), 256'(0));
    for (int s = 0; s < NumSets; s++) check_set_rst(s);
    check({tag, "_toggle"}, 256'(update_toggle), 256'(0));
    check_cnts(tag, 16'd0, 16'd0, 16'd0);
  endtask

  initial begin
    rst_n               = 1'b0;
    in_lu_data          = '0;
    in_lu_data_wr       = 1'b0;
    in_lu_data_valid    = 1'b0;
    in_lu_data_valid_wr = 1'b0;
    for (int k = 0; k < 3; k++) hist[k] = '0;
    repeat (2) @(negedge clk);
    check_all_reset("reset");
    rst_n = 1'b1;
    idle(2);

    // Foreign frame: forwarded with 3-cycle latency, counters untouched.
    send(8, 0, 8, HeadHi, ForeignDst, OtherSrc, 4'h3, 4'h0, '0, 1'b1);
    idle(4);
    check_cnts("foreign", 16'd0, 16'd0, 16'd0);

    // Update to set 2, 12 words; commit lands on the third edge after the tail.
    send(12, 0, 12, HeadHi, LocalMac, OtherSrc, 4'hF, 4'h2, Payload, 1'b0);
    idle(2);
    check("pre_commit_toggle", 256'(update_toggle), 256'(0));
    idle(1);
    check("commit_toggle", 256'(update_toggle), 256'(4'b0100));
    idle(2);
    check_set(2, 32'h1F, 16'h0020, 16'h0400, 48'h0A0B_0C0D_0E0F, 1'b1);
    check_set_rst(0);
    check_set_rst(1);
    check_set_rst(3);
    check_cnts("update", 16'd1, 16'd0, 16'd0);

    // Truncated update (4 words, tail before payload).
    send(4, 0, 4, HeadHi, LocalMac, OtherSrc, 4'hF, 4'h1, Payload2, 1'b0);
    idle(4);
    check_set_rst(1);
    check("trunc_toggle", 256'(update_toggle), 256'(4'b0100));
    check_cnts("trunc", 16'd1, 16'd0, 16'd1);

    // Index 5 is out of range for 4 sets; low bits alias set 1, which must stay untouched.
    send(8, 0, 8, HeadHi, LocalMac, OtherSrc, 4'hF, 4'h5, Payload2, 1'b0);
    idle(4);
    check_set_rst(1);
    check("badidx_toggle", 256'(update_toggle), 256'(4'b0100));
    check_cnts("badidx", 16'd1, 16'd0, 16'd2);

    // Looped frame dropped, foreign frame back-to-back forwarded intact.
    send(6, 0, 6, HeadLo, ForeignDst, LocalMac, 4'h3, 4'h0, '0, 1'b0);
    send(5, 0, 5, HeadHi, ForeignDst, OtherSrc, 4'h1, 4'h0, '0, 1'b1);
    idle(4);
    check_cnts("loop", 16'd1, 16'd1, 16'd2);

    // Head injected mid-update: abandoned, error counted, new frame forwarded.
    send(10, 0, 4, HeadHi, LocalMac, OtherSrc, 4'hF, 4'h3, Payload, 1'b0);
    send(8, 0, 4, HeadHi, ForeignDst, OtherSrc, 4'h1, 4'h0, '0, 1'b1);
    check_cnts("framing", 16'd1, 16'd1, 16'd3);
    check("framing_toggle", 256'(update_toggle), 256'(4'b0100));
    check_set_rst(3);

    // Reset in the middle of the forwarded frame.
    @(negedge clk);
    rst_n               = 1'b0;
    in_lu_data          = '0;
    in_lu_data_wr       = 1'b0;
    in_lu_data_valid    = 1'b0;
    in_lu_data_valid_wr = 1'b0;
    for (int k = 0; k < 3; k++) hist[k] = '0;
    @(negedge clk);
    check_all_reset("in_reset");
    rst_n = 1'b1;
    // Rest of the interrupted frame must be ignored.
    send(8, 4, 8, HeadHi, ForeignDst, OtherSrc, 4'h1, 4'h0, '0, 1'b0);
    idle(4);
    check_all_reset("post_reset");

    // Normal forwarding resumes with the next head.
    send(4, 0, 4, HeadHi, ForeignDst, OtherSrc, 4'h2, 4'h0, '0, 1'b1);
    idle(4);
    check_cnts("resume", 16'd0, 16'd0, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
